// File: rtl/rq_arbiter_if.sv
// RQ AXI-Stream bundle shared by the requester ports and the PCIe core port.
// tready is 4 bits wide to match the hard-core RQ interface; every bit carries
// the same value on the requester side and only bit 0 is meaningful from the core.
interface rq_axis_if #(
  parameter int DATA_W = 128,
  parameter int USER_W = 62,
  parameter int KEEP_W = DATA_W / 32
) ();

  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic [3:0]        tready;

  // Stream producer: drives payload and valid, observes ready.
  modport master (
    output tdata,
    output tuser,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  // Stream consumer: observes payload and valid, drives ready.
  modport slave (
    input  tdata,
    input  tuser,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/rq_arbiter.sv
// Two-port packet-level round-robin arbiter for the PCIe RQ AXI-Stream path.
// Port 0 is the doorbell writer, port 1 the DMA/command requester. The grant is
// held for a whole TLP so beats of different requesters never interleave, and a
// single output register sits in front of the PCIe core.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no grant held; a contest between requesting ports is resolved here
// ST_GNT0 | port 0 owns the output until its tlast beat is accepted
// ST_GNT1 | port 1 owns the output until its tlast beat is accepted
module rq_arbiter #(
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
  input  logic      user_clk,
  input  logic      user_reset,
  input  logic      user_lnk_up,
  rq_axis_if.slave  s0_axis_rq,
  rq_axis_if.slave  s1_axis_rq,
  rq_axis_if.master m_axis_rq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // Link down behaves exactly like reset: in-flight TLP dropped, grant lost.
  logic clr;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;

  logic                           m_tvalid_q, m_tvalid_d;
  logic [C_DATA_WIDTH-1:0]        m_tdata_q, m_tdata_d;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic [KEEP_WIDTH-1:0]          m_tkeep_q, m_tkeep_d;
  logic                           m_tlast_q, m_tlast_d;

  logic can_load;
  logic grant0, grant1;
  logic s0_ready, s1_ready;
  logic s0_accept, s1_accept;
  logic s0_last_accept, s1_last_accept;

  // The core only drives bit 0 meaningfully; the upper bits are ignored.
  logic m_tready_unused;

  assign clr             = user_reset | ~user_lnk_up;
  assign m_tready_unused = ^m_axis_rq.tready[3:1];

  // Output register can take a new beat when empty or being drained this cycle.
  assign can_load = ~m_tvalid_q | m_axis_rq.tready[0];

  assign grant0 = (state_q == ST_GNT0);
  assign grant1 = (state_q == ST_GNT1);

  // Ready is a function of grant state and output occupancy only, never of any
  // source tvalid. Gating with clr keeps a beat from being taken on the very
  // edge that discards the in-flight packet.
  assign s0_ready = grant0 & can_load & ~clr;
  assign s1_ready = grant1 & can_load & ~clr;

  assign s0_axis_rq.tready = {4{s0_ready}};
  assign s1_axis_rq.tready = {4{s1_ready}};

  assign s0_accept      = s0_axis_rq.tvalid & s0_ready;
  assign s1_accept      = s1_axis_rq.tvalid & s1_ready;
  assign s0_last_accept = s0_accept & s0_axis_rq.tlast;
  assign s1_last_accept = s1_accept & s1_axis_rq.tlast;

  // Grant FSM: resolve contests in IDLE, hold the grant until tlast is taken.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_rq.tvalid && s1_axis_rq.tvalid) begin
          // Both requesting: the port that did not win last time goes next.
          if (last_grant_q) begin
            state_d      = ST_GNT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = ST_GNT1;
            last_grant_d = 1'b1;
          end
        end else if (s0_axis_rq.tvalid) begin
          state_d      = ST_GNT0;
          last_grant_d = 1'b0;
        end else if (s1_axis_rq.tvalid) begin
          state_d      = ST_GNT1;
          last_grant_d = 1'b1;
        end
      end
      ST_GNT0: begin
        if (s0_last_accept) begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (s1_last_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: load on accept, drain when the core takes it, else hold.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    if (s0_accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s0_axis_rq.tdata;
      m_tuser_d  = s0_axis_rq.tuser;
      m_tkeep_d  = s0_axis_rq.tkeep;
      m_tlast_d  = s0_axis_rq.tlast;
    end else if (s1_accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s1_axis_rq.tdata;
      m_tuser_d  = s1_axis_rq.tuser;
      m_tkeep_d  = s1_axis_rq.tkeep;
      m_tlast_d  = s1_axis_rq.tlast;
    end else if (m_axis_rq.tready[0]) begin
      // Payload fields are left as-is; only valid drops once consumed.
      m_tvalid_d = 1'b0;
    end
  end

  // State and output flops; reset or link loss clears everything on the next edge.
  always_ff @(posedge user_clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tuser_q    <= '0;
      m_tkeep_q    <= '0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tuser_q    <= m_tuser_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  assign m_axis_rq.tvalid = m_tvalid_q;
  assign m_axis_rq.tdata  = m_tdata_q;
  assign m_axis_rq.tuser  = m_tuser_q;
  assign m_axis_rq.tkeep  = m_tkeep_q;
  assign m_axis_rq.tlast  = m_tlast_q;

endmodule

// File: tb/tb_rq_arbiter.sv
// Bench for rq_arbiter: per-port source drivers feed directed TLPs, expected
// output beats are queued in hand-computed order, and a monitor pops and
// compares every beat the core accepts.
module tb_rq_arbiter;

  logic user_clk = 1'b0;
  logic user_reset;
  logic user_lnk_up;

  always #5 user_clk = ~user_clk;

  rq_axis_if #(.DATA_W(128), .USER_W(62), .KEEP_W(4)) s0_if ();
  rq_axis_if #(.DATA_W(128), .USER_W(62), .KEEP_W(4)) s1_if ();
  rq_axis_if #(.DATA_W(128), .USER_W(62), .KEEP_W(4)) m_if ();

  rq_arbiter #(
    .AXI4_RQ_TUSER_WIDTH(62),
    .C_DATA_WIDTH       (128),
    .KEEP_WIDTH         (4)
  ) dut (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .user_lnk_up(user_lnk_up),
    .s0_axis_rq (s0_if),
    .s1_axis_rq (s1_if),
    .m_axis_rq  (m_if)
  );

  typedef struct {
    logic [127:0] data;
    logic [61:0]  user;
    logic [3:0]   keep;
    logic         last;
    int           gap;   // cycles with tvalid low before this beat
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  int    out_cyc[$];

  int    n_cmp;
  int    n_err;
  int    cyc = 0;
  int    vld_cnt;
  logic  s1_rdy_seen;
  logic  busy0, busy1;
  beat_t mon_e;

  always @(posedge user_clk) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [127:0] d, input logic [3:0] k,
                               input logic l, input int g);
    beat_t b;
    b.data = d;
    b.user = d[61:0] ^ 62'h15A5_A5A5_A5A5_A5A5;
    b.keep = k;
    b.last = l;
    b.gap  = g;
    return b;
  endfunction

  function automatic int oc(input int i);
    if (i < out_cyc.size()) return out_cyc[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every beat the core accepts must be the next expected one.
  always @(negedge user_clk) begin
    if (m_if.tvalid === 1'b1 && m_if.tready[0] === 1'b1) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", m_if.tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_tdata", m_if.tdata, mon_e.data);
        chk("out_tuser", 128'(m_if.tuser), 128'(mon_e.user));
        chk("out_tkeep", 128'(m_if.tkeep), 128'(mon_e.keep));
        chk("out_tlast", 128'(m_if.tlast), 128'(mon_e.last));
      end
    end
    if (m_if.tvalid === 1'b1) vld_cnt++;
    if (s1_if.tready !== 4'h0) s1_rdy_seen = 1'b1;
  end

  task automatic set_src(input int p, input beat_t b);
    if (p == 0) begin
      s0_if.tdata = b.data; s0_if.tuser = b.user; s0_if.tkeep = b.keep;
      s0_if.tlast = b.last; s0_if.tvalid = 1'b1;
    end else begin
      s1_if.tdata = b.data; s1_if.tuser = b.user; s1_if.tkeep = b.keep;
      s1_if.tlast = b.last; s1_if.tvalid = 1'b1;
    end
  endtask

  task automatic drop_valid(input int p);
    if (p == 0) s0_if.tvalid = 1'b0;
    else        s1_if.tvalid = 1'b0;
  endtask

  function automatic logic src_rdy(input int p);
    if (p == 0) return s0_if.tready[0];
    return s1_if.tready[0];
  endfunction

  // Source driver: presents each queued beat until the arbiter takes it.
  task automatic drv(input int p);
    beat_t b;
    int    t;
    forever begin
      if (p == 0 && q0.size() == 0) break;
      if (p == 1 && q1.size() == 0) break;
      if (p == 0) b = q0.pop_front();
      else        b = q1.pop_front();
      if (b.gap > 0) begin
        repeat (b.gap) @(posedge user_clk);
        #1;
      end
      set_src(p, b);
      t = 0;
      do begin
        @(negedge user_clk);
        t++;
      end while (src_rdy(p) !== 1'b1 && t < 64);
      if (src_rdy(p) !== 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL drv%0d_ready_timeout: got tready=0, expected 1 within 64 cycles", p);
        drop_valid(p);
        if (p == 0) q0.delete();
        else        q1.delete();
        break;
      end
      @(posedge user_clk);
      #1;
      drop_valid(p);
    end
    if (p == 0) busy0 = 1'b0;
    else        busy1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge user_clk);
    #1;
    user_reset   = 1'b1;
    s0_if.tvalid = 1'b0;
    s1_if.tvalid = 1'b0;
    m_if.tready  = 4'hF;
    repeat (2) @(posedge user_clk);
    #1;
    user_reset  = 1'b0;
    out_cyc.delete();
    vld_cnt     = 0;
    s1_rdy_seen = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy0 || busy1) && t < 300) begin
      @(negedge user_clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy0 || busy1) begin
      n_err++;
      $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge user_clk);
  endtask

  task automatic start_drv(input int p);
    if (p == 0) begin
      busy0 = 1'b1;
      fork drv(0); join_none
    end else begin
      busy1 = 1'b1;
      fork drv(1); join_none
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b, b0, b1, b2;
    int    start;
    int    t;
    logic  found;

    n_cmp = 0; n_err = 0; vld_cnt = 0; s1_rdy_seen = 1'b0;
    busy0 = 1'b0; busy1 = 1'b0;
    user_reset = 1'b1; user_lnk_up = 1'b1;
    s0_if.tdata = '0; s0_if.tuser = '0; s0_if.tkeep = '0; s0_if.tlast = 1'b0; s0_if.tvalid = 1'b0;
    s1_if.tdata = '0; s1_if.tuser = '0; s1_if.tkeep = '0; s1_if.tlast = 1'b0; s1_if.tvalid = 1'b0;
    m_if.tready = 4'hF;

    // Reset state
    do_reset();
    @(negedge user_clk);
    chk("rst_m_tvalid", 128'(m_if.tvalid), 128'd0);
    chk("rst_m_tdata",  m_if.tdata, 128'd0);
    chk("rst_m_tuser",  128'(m_if.tuser), 128'd0);
    chk("rst_m_tkeep",  128'(m_if.tkeep), 128'd0);
    chk("rst_m_tlast",  128'(m_if.tlast), 128'd0);
    chk("rst_s0_tready", 128'(s0_if.tready), 128'd0);
    chk("rst_s1_tready", 128'(s1_if.tready), 128'd0);

    // Doorbell-only 2-beat TLP: latency 2, exactly 2 valid cycles
    do_reset();
    b = mk(128'hD00B_BE11_0000_0000_0000_0000_0000_0001, 4'hF, 1'b0, 0);
    q0.push_back(b); exp_q.push_back(b);
    b = mk(128'h5, 4'h3, 1'b1, 0);
    q0.push_back(b); exp_q.push_back(b);
    start = cyc;
    start_drv(0);
    repeat (2) @(negedge user_clk);
    chk("db_s0_tready", 128'(s0_if.tready), 128'hF);
    wait_done("db");
    chk("db_lat_beat0", 128'(oc(0)), 128'(start + 2));
    chk("db_lat_beat1", 128'(oc(1)), 128'(start + 3));
    chk("db_valid_cycles", 128'(vld_cnt), 128'd2);
    chk("db_s1_tready_idle", 128'(s1_rdy_seen), 128'd0);
    chk("db_hold_data", m_if.tdata, 128'h5);

    // Both ports contending continuously: packets alternate 0,1,0,1
    do_reset();
    for (int k = 0; k < 2; k++) begin
      b0 = mk(128'h3000 + 128'(k * 16),     4'hF, 1'b0, 0);
      b1 = mk(128'h3001 + 128'(k * 16),     4'h7, 1'b1, 0);
      b2 = mk(128'h4000 + 128'(k * 16),     4'hF, 1'b0, 0);
      b  = mk(128'h4001 + 128'(k * 16),     4'h1, 1'b1, 0);
      q0.push_back(b0); q0.push_back(b1);
      q1.push_back(b2); q1.push_back(b);
      exp_q.push_back(b0); exp_q.push_back(b1);
      exp_q.push_back(b2); exp_q.push_back(b);
    end
    start_drv(0);
    start_drv(1);
    wait_done("rr");
    chk("rr_beat_count", 128'(out_cyc.size()), 128'd8);

    // Core backpressure on beat1 of a 3-beat port-1 TLP (bit 0 low, others high)
    do_reset();
    b0 = mk(128'h1111_0000_0000_0000_0000_0000_0000_0000, 4'hF, 1'b0, 0);
    b1 = mk(128'h2222_0000_0000_0000_0000_0000_0000_0000, 4'h7, 1'b0, 0);
    b2 = mk(128'h3333_0000_0000_0000_0000_0000_0000_0000, 4'h1, 1'b1, 0);
    q1.push_back(b0); q1.push_back(b1); q1.push_back(b2);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    start_drv(1);
    t = 0;
    found = 1'b0;
    while (!found && t < 20) begin
      @(negedge user_clk);
      t++;
      if (m_if.tvalid === 1'b1 && m_if.tdata === b0.data) found = 1'b1;
    end
    chk("stall_beat0_seen", 128'(found), 128'd1);
    @(posedge user_clk);
    #1;
    m_if.tready = 4'hE;
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      chk("stall_tdata", m_if.tdata, b1.data);
      chk("stall_tkeep", 128'(m_if.tkeep), 128'(b1.keep));
      chk("stall_tlast", 128'(m_if.tlast), 128'd0);
      chk("stall_s1_tready", 128'(s1_if.tready), 128'd0);
    end
    @(posedge user_clk);
    #1;
    m_if.tready = 4'hF;
    wait_done("stall");
    chk("stall_beat_count", 128'(out_cyc.size()), 128'd3);

    // Port-1 source gaps mid-packet while port 0 waits: grant stays on port 1
    do_reset();
    b0 = mk(128'hA100, 4'hF, 1'b0, 0);
    b1 = mk(128'hA101, 4'h3, 1'b1, 2);
    q1.push_back(b0); q1.push_back(b1);
    b2 = mk(128'hB000, 4'hF, 1'b0, 1);
    b  = mk(128'hB001, 4'h1, 1'b1, 0);
    q0.push_back(b2); q0.push_back(b);
    exp_q.push_back(b0); exp_q.push_back(b1);
    exp_q.push_back(b2); exp_q.push_back(b);
    start_drv(1);
    start_drv(0);
    wait_done("gap");
    chk("gap_beat_count", 128'(out_cyc.size()), 128'd4);

    // Link drop right after beat0 of a port-0 TLP
    do_reset();
    b0 = mk(128'hC0DE_0000, 4'hF, 1'b0, 0);
    b1 = mk(128'hC0DE_0001, 4'h3, 1'b1, 0);
    exp_q.push_back(b0);
    set_src(0, b0);
    @(posedge user_clk);
    @(negedge user_clk);
    chk("lnk_s0_tready", 128'(s0_if.tready), 128'hF);
    @(posedge user_clk);
    #1;
    set_src(0, b1);
    user_lnk_up  = 1'b0;
    s0_if.tvalid = 1'b0;
    @(posedge user_clk);
    #1;
    user_lnk_up = 1'b1;
    @(negedge user_clk);
    chk("lnk_m_tvalid", 128'(m_if.tvalid), 128'd0);
    chk("lnk_m_tdata",  m_if.tdata, 128'd0);
    chk("lnk_m_tuser",  128'(m_if.tuser), 128'd0);
    chk("lnk_m_tkeep",  128'(m_if.tkeep), 128'd0);
    chk("lnk_m_tlast",  128'(m_if.tlast), 128'd0);
    chk("lnk_s0_tready_clr", 128'(s0_if.tready), 128'd0);
    chk("lnk_s1_tready_clr", 128'(s1_if.tready), 128'd0);
    @(posedge user_clk);
    #1;
    out_cyc.delete();
    b0 = mk(128'hD1D1, 4'hF, 1'b0, 0);
    b1 = mk(128'hD1D2, 4'h7, 1'b1, 0);
    q1.push_back(b0); q1.push_back(b1);
    exp_q.push_back(b0); exp_q.push_back(b1);
    start = cyc;
    start_drv(1);
    wait_done("lnk");
    chk("lnk_fresh_lat", 128'(oc(0)), 128'(start + 2));
    chk("lnk_fresh_count", 128'(out_cyc.size()), 128'd2);

    // Back-to-back single-beat TLPs on port 1: one beat every 2 cycles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      b = mk(128'hE000 + 128'(k), 4'h1 + 4'(k), 1'b1, 0);
      q1.push_back(b);
      exp_q.push_back(b);
    end
    start = cyc;
    start_drv(1);
    wait_done("single");
    chk("single_count", 128'(out_cyc.size()), 128'd4);
    chk("single_lat", 128'(oc(0)), 128'(start + 2));
    for (int i = 1; i < 4; i++) begin
      chk("single_spacing", 128'(oc(i) - oc(i - 1)), 128'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rq_arbiter.md
Name: rq_arbiter

Overview:
- Two-port, packet-level round-robin arbiter for the PCIe Requester reQuest (RQ) AXI-Stream path.
- Sits directly downstream of the doorbell writer (port 0) and the DMA/command requester (port 1). Drives the single RQ interface of the PCIe hard core.
- Grant is locked for a whole TLP (until tlast is accepted), so beats from different requesters never interleave.
- Has one registered output stage for timing closure.

Parameters:
AXI4_RQ_TUSER_WIDTH, 62, RQ tuser width
C_DATA_WIDTH, 128, RQ tdata width
KEEP_WIDTH, C_DATA_WIDTH/32, RQ tkeep width (dword granularity)

Ports:
user_clk  input  1  single clock for all logic
user_reset  input  1  synchronous, active-high reset
user_lnk_up  input  1  PCIe link up; low acts as synchronous reset
s0_axis_rq_tdata  input  C_DATA_WIDTH  port 0 (doorbell) data
s0_axis_rq_tuser  input  AXI4_RQ_TUSER_WIDTH  port 0 user
s0_axis_rq_tkeep  input  KEEP_WIDTH  port 0 keep
s0_axis_rq_tlast  input  1  port 0 last beat
s0_axis_rq_tvalid  input  1  port 0 valid
s0_axis_rq_tready  output  4  port 0 ready, one value replicated on all 4 bits
s1_axis_rq_tdata/tuser/tkeep/tlast/tvalid  input  as port 0  port 1 (DMA requester)
s1_axis_rq_tready  output  4  port 1 ready, replicated
m_axis_rq_tdata  output  C_DATA_WIDTH  to PCIe core
m_axis_rq_tuser  output  AXI4_RQ_TUSER_WIDTH  to PCIe core
m_axis_rq_tkeep  output  KEEP_WIDTH  to PCIe core
m_axis_rq_tlast  output  1  to PCIe core
m_axis_rq_tvalid  output  1  to PCIe core
m_axis_rq_tready  input  4  from PCIe core; only bit 0 is used

Behaviour:
- Reset (user_reset high or user_lnk_up low, sampled on user_clk):
  - state = ST_IDLE; last_grant = 1, so port 0 wins the first contest.
  - All m_* outputs = 0; s0/s1 tready = 4'b0000.
- States:
  - ST_IDLE:
    - Only s1 valid -> ST_GNT1.
    - Only s0 valid -> ST_GNT0.
    - Both valid -> the port that is not last_grant wins; last_grant is updated on the transition.
    - Neither valid -> stay in ST_IDLE.
  - ST_GNT0 / ST_GNT1: beats accepted only from the granted port. After the beat with tlast=1 is accepted -> ST_IDLE.
- Output register:
  - can_load = !m_axis_rq_tvalid || m_axis_rq_tready[0].
  - Granted port tready = {4{can_load}} while in ST_GNTx. Non-granted port tready = 0. Both are 0 in ST_IDLE.
  - tready is combinational from state and the output register. It has no combinational path from any s*_tvalid.
  - Accept = granted tvalid && granted tready. On accept, tdata/tuser/tkeep/tlast are copied into m_* and m_tvalid <= 1.
  - Else if m_axis_rq_tready[0]: m_tvalid <= 0. Data fields keep their value.
  - While m_tvalid=1 and m_axis_rq_tready[0]=0, all m_* hold stable.
- Latency:
  - Source valid at cycle t (ST_IDLE, output empty) -> tready high at t+1 -> m_tvalid at t+2.
  - Full throughput within a packet.
  - One idle-state bubble between packets.
- Fairness: with both ports continuously requesting, granted packets strictly alternate 0,1,0,1.
- tlast on the first beat (single-beat TLP) is legal; the block returns to ST_IDLE after that one beat.
- Link drop or reset mid-packet:
  - The in-flight TLP is discarded and m_tvalid is cleared immediately (next edge).
  - Grant is lost; state returns to ST_IDLE with last_grant = 1.
  - Upstream sources are reset by the same condition.
- A source deasserting tvalid mid-packet only stalls the transfer; grant is held until tlast is accepted.
- No internal timeout. A source that never delivers tlast locks the arbiter; this is a source protocol violation.

Test Plan:
- Doorbell-only 2-beat TLP (beat0 tkeep=4'hF tlast=0; beat1 tdata[63:0]=64'h5, tkeep=4'h3, tlast=1), m_tready=4'hF -> m_tvalid for exactly 2 cycles starting 2 cycles after s0_tvalid. Data matches beat-for-beat; s1_tready=0 throughout.
- Both ports present one 2-beat TLP in the same cycle after reset -> port 0 TLP emitted first, then port 1. A second simultaneous contest grants port 1 first is NOT expected: it grants port 0 (alternation), giving order 0,1,0,1 over four packets.
- m_axis_rq_tready=0 for 3 cycles on beat1 of a 3-beat port-1 TLP -> m_tdata/m_tkeep/m_tlast constant for those 3 cycles, s1_tready=0, then remaining beats delivered in order with no loss or duplication.
- Port-1 source deasserts tvalid for 2 cycles between beat0 and beat1 while port 0 is requesting -> port 0 is not granted until port 1's tlast is accepted.
- user_lnk_up dropped for 1 cycle after beat0 of a port-0 TLP -> next cycle all m_* = 0 and both tready = 0. After link up, a fresh port-1-only request is granted normally.
- Single-beat TLPs (tlast=1) back-to-back on port 1 only -> one output beat every 2 cycles, each with tlast=1.
